// File: rtl/lsu_mem_master.sv
// Load/store initiator between the CPU datapath and a word-only data memory.
// Serialises one request at a time into word read / write strobes, handles
// RV32I sub-word load extension and read-modify-write for byte/half stores,
// and rejects misaligned, illegal or out-of-range accesses without a memory cycle.
module lsu_mem_master #(
    parameter int MEM_DEPTH = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_out
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic        store_r;
    logic        err_r;
    logic [2:0]  funct3_r;
    logic [1:0]  addr_lo_r;
    logic [31:0] wdata_r;
    logic [31:0] word_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_din_r;
    logic        accept;
    logic        req_err;

    // Classify a request: illegal funct3 for its direction, misalignment, or word index past the memory.
    function automatic logic classify_error(input logic store, input logic [2:0] f3,
                                            input logic [31:0] addr);
        logic illegal;
        logic misaligned;
        logic out_of_range;
        if (store)
            illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        else
            illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                        f3 == 3'b100 || f3 == 3'b101);
        misaligned   = (f3[1:0] == 2'b01 && addr[0]) ||
                       (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        out_of_range = ({2'b00, addr[31:2]} >= 32'(MEM_DEPTH));
        return illegal || misaligned || out_of_range;
    endfunction

    // Pick the addressed byte/half lane and sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  result = {{24{b[7]}}, b};
            3'b001:  result = {{16{h[15]}}, h};
            3'b100:  result = {24'd0, b};
            3'b101:  result = {16'd0, h};
            default: result = word;
        endcase
        return result;
    endfunction

    // Insert store data into the read word at the addressed lane.
    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word, input logic [31:0] wdata);
        logic [31:0] result;
        result = word;
        if (f3 == 3'b000)
            result[{lo, 3'b000} +: 8] = wdata[7:0];
        else if (f3 == 3'b001)
            result[{lo[1], 4'b0000} +: 16] = wdata[15:0];
        else
            result = wdata;
        return result;
    endfunction

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign req_err   = classify_error(req_store, req_funct3, req_addr);

    // State register; reset folds into the next-state logic.
    always_ff @(posedge clk) begin
        state <= state_next;
    end

    // Next-state decode: route each accepted request through read and/or write phases.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = RESP;
                    else if (!req_store)
                        state_next = RD;
                    else if (req_funct3 == 3'b010)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = store_r ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (reset)
            state_next = IDLE;
    end

    // Request capture, memory address/write word setup and read-word sampling.
    always_ff @(posedge clk) begin
        if (reset) begin
            store_r    <= 1'b0;
            err_r      <= 1'b0;
            mem_addr_r <= 32'd0;
            mem_din_r  <= 32'd0;
        end else begin
            if (accept) begin
                store_r   <= req_store;
                err_r     <= req_err;
                funct3_r  <= req_funct3;
                addr_lo_r <= req_addr[1:0];
                wdata_r   <= req_wdata;
                if (!req_err) begin
                    mem_addr_r <= {req_addr[31:2], 2'b00};
                    if (req_store && req_funct3 == 3'b010)
                        mem_din_r <= req_wdata;
                end
            end
            if (state == RD) begin
                word_r <= mem_out;
                if (store_r)
                    mem_din_r <= store_merge(funct3_r, addr_lo_r, mem_out, wdata_r);
            end
        end
    end

    assign mem_addr   = mem_addr_r;
    assign mem_din    = mem_din_r;
    assign mem_read   = (state == RD) && !reset;
    assign mem_write  = (state == WR) && !reset;
    assign resp_valid = (state == RESP) && !reset;
    assign resp_err   = resp_valid && err_r;
    assign resp_rdata = (resp_valid && !err_r && !store_r) ?
                        load_extract(funct3_r, addr_lo_r, word_r) : 32'd0;

endmodule
